comb_row_requester: RTL

- Initiator-side sequencer for the stack-based combination core, which is a start/done responder computing C(n,m).
- Accepts a single row request n and issues C(n,m) requests to the core for m = 0..n in ascending order.
- Collects each core result and streams it out over a valid/ready interface.
- Sits between a host/test harness and the combination core, and is the only master of the core's start/n/m inputs.

---
 rtl/comb_row_requester.sv | 129 ++++++++++++
 1 files changed

// File: rtl/comb_row_requester.sv
// Row sequencer for the combination core: issues C(n,m) for m = 0..n and streams results out.
// Optional macro COMB_ROW_SUM_EN adds a row accumulator with row_sum/sum_ok outputs.
module comb_row_requester #(
  parameter int N_W = 4,
  parameter int R_W = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           core_start,
  output logic [N_W-1:0] core_n,
  output logic [N_W-1:0] core_m,
  input  logic           core_done,
  input  logic [R_W-1:0] core_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] out_m,
  output logic [R_W-1:0] out_data,
  output logic           out_last,
`ifdef COMB_ROW_SUM_EN
  output logic [N_W+R_W-1:0] row_sum,
  output logic           sum_ok,
`endif
  output logic           row_done
);

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_issue = 3'd1;
  localparam logic [2:0] st_wait  = 3'd2;
  localparam logic [2:0] st_out   = 3'd3;
  localparam logic [2:0] st_fin   = 3'd4;

  logic [2:0]     state_reg;
  logic [N_W-1:0] core_n_reg;
  logic [N_W-1:0] m_reg;
  logic           out_valid_reg;
  logic           out_last_reg;
  logic [N_W-1:0] out_m_reg;
  logic [R_W-1:0] out_data_reg;

`ifdef COMB_ROW_SUM_EN
  localparam logic [N_W+R_W-1:0] sum_one = 1;
  logic [N_W+R_W-1:0] acc_reg;
  logic               sum_ok_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= st_idle;
      core_n_reg    <= '0;
      m_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_m_reg     <= '0;
      out_data_reg  <= '0;
`ifdef COMB_ROW_SUM_EN
      acc_reg       <= '0;
      sum_ok_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        st_idle: begin
          if (start) begin
            core_n_reg <= n;
            m_reg      <= '0;
            state_reg  <= st_issue;
`ifdef COMB_ROW_SUM_EN
            acc_reg    <= '0;
            sum_ok_reg <= 1'b0;
`endif
          end
        end
        // core_done is not looked at here, so a stale done cannot be mistaken for this request
        st_issue: state_reg <= st_wait;
        st_wait: begin
          if (core_done) begin
            out_data_reg  <= core_result;
            out_m_reg     <= m_reg;
            out_valid_reg <= 1'b1;
            out_last_reg  <= (m_reg == core_n_reg);
            state_reg     <= st_out;
          end
        end
        st_out: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
`ifdef COMB_ROW_SUM_EN
            acc_reg       <= acc_reg + {{N_W{1'b0}}, out_data_reg};
`endif
            // terminating on m == n keeps the counter from wrapping at the maximum n
            if (out_last_reg) begin
              state_reg <= st_fin;
            end else begin
              m_reg     <= m_reg + N_W'(1);
              state_reg <= st_issue;
            end
          end
        end
        st_fin: begin
`ifdef COMB_ROW_SUM_EN
          sum_ok_reg <= (acc_reg == (sum_one << core_n_reg));
`endif
          state_reg <= st_idle;
        end
        default: state_reg <= st_idle;
      endcase
    end
  end

  assign busy       = (state_reg == st_issue) || (state_reg == st_wait) || (state_reg == st_out);
  assign core_start = (state_reg == st_issue);
  assign row_done   = (state_reg == st_fin);
  assign core_n     = core_n_reg;
  assign core_m     = m_reg;
  assign out_valid  = out_valid_reg;
  assign out_last   = out_last_reg;
  assign out_m      = out_m_reg;
  assign out_data   = out_data_reg;

`ifdef COMB_ROW_SUM_EN
  assign row_sum = acc_reg;
  // the verdict is visible in the row_done cycle itself, then held in sum_ok_reg
  assign sum_ok  = (state_reg == st_fin) ? (acc_reg == (sum_one << core_n_reg)) : sum_ok_reg;
`endif

endmodule
